// File: rtl/sync_to_async_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_to_async_fifo_ctrl
// Description : Buffered bridge from a clocked ready/valid port to a
//               bundled-data req/ack channel (four-phase or two-phase).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_to_async_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int SYNC_STAGE = 2,
  parameter int TWO_PHASE  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sync_valid,
  output logic                       sync_ready,
  input  logic [DATA_WIDTH-1:0]      sync_d,
  output logic                       async_req,
  input  logic                       async_ack,
  output logic [DATA_WIDTH-1:0]      async_d,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETUP    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_WAIT_RTZ = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [LVL_W-1:0]        level_next;
  logic [SYNC_STAGE-1:0]   ack_sync;
  logic                    ack_s;
  logic                    push;
  logic                    pop;
  logic                    load;
  logic                    req_next;

  assign push  = sync_valid & sync_ready;
  assign ack_s = ack_sync[SYNC_STAGE-1];

  // Synchronizer chain bringing the self-timed acknowledge into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync[0] <= async_ack;
      for (int i = 1; i < SYNC_STAGE; i++) begin
        ack_sync[i] <= ack_sync[i-1];
      end
    end
  end

  // Storage write; entries need no reset since the level gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= sync_d;
    end
  end

  // Read/write pointers, wrapping naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy after this edge; a coincident push and pop cancel out.
  always_comb begin
    level_next = fifo_level;
    if (push && !pop) begin
      level_next = fifo_level + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = fifo_level - LVL_W'(1);
    end
  end

  // Registered status so sync_ready, level and idle all reflect post-edge state.
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_level <= '0;
      sync_ready <= 1'b0;
      idle       <= 1'b1;
    end else begin
      fifo_level <= level_next;
      sync_ready <= (level_next != LVL_W'(DEPTH));
      idle       <= (level_next == '0) && (state_next == S_IDLE);
    end
  end

  // Handshake state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: load head, set up data, raise/toggle req, retire on ack.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    pop        = 1'b0;
    req_next   = async_req;
    case (state)
      S_IDLE: begin
        if (fifo_level != '0) begin
          load       = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        req_next   = (TWO_PHASE != 0) ? ~async_req : 1'b1;
        state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (TWO_PHASE != 0) begin
          if (ack_s == async_req) begin
            pop        = 1'b1;
            state_next = S_IDLE;
          end
        end else if (ack_s) begin
          pop        = 1'b1;
          req_next   = 1'b0;
          state_next = S_WAIT_RTZ;
        end
      end
      S_WAIT_RTZ: begin
        if (!ack_s) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bundled data and request outputs; data only changes on the IDLE->SETUP load.
  always_ff @(posedge clock) begin
    if (reset) begin
      async_req <= 1'b0;
      async_d   <= '0;
    end else begin
      async_req <= req_next;
      if (load) begin
        async_d <= mem[rd_ptr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_to_async_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_to_async_fifo_ctrl
// Description : Directed self-checking bench for sync_to_async_fifo_ctrl,
//               one four-phase and one two-phase instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_to_async_fifo_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // four-phase instance
  logic       v4 = 1'b0;
  logic [7:0] d4 = 8'h00;
  logic       rdy4, req4, idle4, ack4;
  logic [7:0] ad4;
  logic [2:0] lvl4;
  logic       auto4 = 1'b0, man_ack4 = 1'b0, resp_ack4 = 1'b0;
  int         cnt4 = 0;
  logic       req4_prev = 1'b0;
  logic [7:0] q4[$];

  // two-phase instance
  logic       v2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       rdy2, req2, idle2, ack2;
  logic [7:0] ad2;
  logic [2:0] lvl2;
  int         cnt2 = 0;
  logic       req2_prev = 1'b0;
  logic [7:0] q2[$];
  int         t2[$];

  assign ack4 = auto4 ? resp_ack4 : man_ack4;

  sync_to_async_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_STAGE(2), .TWO_PHASE(0)) dut4 (
    .clock(clock), .reset(reset), .sync_valid(v4), .sync_ready(rdy4), .sync_d(d4),
    .async_req(req4), .async_ack(ack4), .async_d(ad4), .fifo_level(lvl4), .idle(idle4)
  );

  sync_to_async_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_STAGE(2), .TWO_PHASE(1)) dut2 (
    .clock(clock), .reset(reset), .sync_valid(v2), .sync_ready(rdy2), .sync_d(d2),
    .async_req(req2), .async_ack(ack2), .async_d(ad2), .fifo_level(lvl2), .idle(idle2)
  );

  // Four-phase responder: follows req on the third falling edge that sees a mismatch.
  always @(negedge clock) begin
    if (auto4 && (req4 !== resp_ack4)) begin
      if (cnt4 == 2) begin
        resp_ack4 <= req4;
        cnt4      <= 0;
      end else begin
        cnt4 <= cnt4 + 1;
      end
    end else begin
      cnt4 <= 0;
    end
  end

  // Two-phase responder: toggles ack two falling edges after each req edge.
  always @(negedge clock) begin
    if (req2 !== ack2) begin
      if (cnt2 == 1) begin
        ack2 <= req2;
        cnt2 <= 0;
      end else begin
        cnt2 <= cnt2 + 1;
      end
    end else begin
      cnt2 <= 0;
    end
  end

  initial ack2 = 1'b0;

  // Record data presented with every new request.
  always @(negedge clock) begin
    if (req4 && !req4_prev) q4.push_back(ad4);
    req4_prev <= req4;
    if (req2 !== req2_prev) begin
      q2.push_back(ad2);
      t2.push_back(cyc);
    end
    req2_prev <= req2;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle4(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (idle4) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_rdy4(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rdy4) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_rdy2(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rdy2) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_idle2(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (idle2) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (rdy4 !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy4); else n_pass++;
    n_checks++; if (req4 !== 1'b0) $display("FAIL reset_req: got %b want 0", req4); else n_pass++;
    n_checks++; if (ad4 !== 8'h00) $display("FAIL reset_data: got %h want 00", ad4); else n_pass++;
    n_checks++; if (lvl4 !== 3'd0) $display("FAIL reset_level: got %0d want 0", lvl4); else n_pass++;
    n_checks++; if (idle4 !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle4); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (rdy4 !== 1'b1) $display("FAIL reset_ready_rise: got %b want 1", rdy4); else n_pass++;
    n_checks++; if (rdy2 !== 1'b1) $display("FAIL reset_ready_rise2: got %b want 1", rdy2); else n_pass++;
  endtask

  task automatic test_single();
    int n;
    auto4 = 1'b1;
    q4.delete();
    v4 = 1'b1; d4 = 8'hA5;
    tick();
    v4 = 1'b0;
    n_checks++; if (lvl4 !== 3'd1) $display("FAIL single_level1: got %0d want 1", lvl4); else n_pass++;
    n_checks++; if (idle4 !== 1'b0) $display("FAIL single_busy: got %b want 0", idle4); else n_pass++;
    n_checks++; if (req4 !== 1'b0) $display("FAIL single_req_early: got %b want 0", req4); else n_pass++;
    tick();
    n_checks++; if (ad4 !== 8'hA5) $display("FAIL single_setup_data: got %h want a5", ad4); else n_pass++;
    n_checks++; if (req4 !== 1'b0) $display("FAIL single_setup_req: got %b want 0", req4); else n_pass++;
    tick();
    n_checks++; if (req4 !== 1'b1) $display("FAIL single_req_rise: got %b want 1", req4); else n_pass++;
    n = 0;
    while (req4 && n < 20) begin tick(); n++; end
    n_checks++; if (n != 5) $display("FAIL single_req_fall_delay: got %0d want 5", n); else n_pass++;
    n_checks++; if (lvl4 !== 3'd0) $display("FAIL single_level0: got %0d want 0", lvl4); else n_pass++;
    n_checks++; if (ack4 !== 1'b1) $display("FAIL single_ack_at_fall: got %b want 1", ack4); else n_pass++;
    n = 0;
    while (!idle4 && n < 20) begin tick(); n++; end
    n_checks++; if (n != 5) $display("FAIL single_idle_delay: got %0d want 5", n); else n_pass++;
  endtask

  task automatic test_fill();
    bit ok;
    auto4 = 1'b0; man_ack4 = 1'b0;
    q4.delete();
    for (int i = 0; i < 4; i++) begin
      d4 = 8'(i + 1); v4 = 1'b1;
      n_checks++; if (rdy4 !== 1'b1) $display("FAIL fill_ready_%0d: got %b want 1", i, rdy4); else n_pass++;
      tick();
    end
    n_checks++; if (lvl4 !== 3'd4) $display("FAIL fill_level_full: got %0d want 4", lvl4); else n_pass++;
    n_checks++; if (rdy4 !== 1'b0) $display("FAIL fill_ready_full: got %b want 0", rdy4); else n_pass++;
    d4 = 8'h05;
    repeat (5) tick();
    n_checks++; if (lvl4 !== 3'd4) $display("FAIL fill_level_held: got %0d want 4", lvl4); else n_pass++;
    n_checks++; if (rdy4 !== 1'b0) $display("FAIL fill_ready_held: got %b want 0", rdy4); else n_pass++;
    n_checks++; if (req4 !== 1'b1) $display("FAIL fill_req_stuck: got %b want 1", req4); else n_pass++;
    n_checks++; if (ad4 !== 8'h01) $display("FAIL fill_head_data: got %h want 01", ad4); else n_pass++;
    auto4 = 1'b1;
    wait_rdy4(40, ok);
    n_checks++; if (!ok) $display("FAIL fill_ready_timeout: got 0 want 1"); else n_pass++;
    n_checks++; if (lvl4 !== 3'd3) $display("FAIL fill_level_after_pop: got %0d want 3", lvl4); else n_pass++;
    tick();
    v4 = 1'b0;
    n_checks++; if (lvl4 !== 3'd4) $display("FAIL fill_level_fifth: got %0d want 4", lvl4); else n_pass++;
    wait_idle4(200, ok);
    n_checks++; if (!ok) $display("FAIL fill_drain_timeout: got 0 want 1"); else n_pass++;
    n_checks++; if (q4.size() != 5) $display("FAIL fill_count: got %0d want 5", q4.size()); else n_pass++;
    for (int i = 0; i < 5 && i < q4.size(); i++) begin
      n_checks++; if (q4[i] !== 8'(i + 1)) $display("FAIL fill_order_%0d: got %h want %h", i, q4[i], 8'(i + 1)); else n_pass++;
    end
  endtask

  task automatic test_simul_wrap();
    bit ok;
    logic [7:0] exp3 [3];
    exp3[0] = 8'h20; exp3[1] = 8'h21; exp3[2] = 8'h22;
    auto4 = 1'b0; man_ack4 = 1'b0;
    q4.delete();
    v4 = 1'b1; d4 = 8'h20; tick();
    d4 = 8'h21; tick();
    v4 = 1'b0;
    tick(); tick();
    n_checks++; if (lvl4 !== 3'd2) $display("FAIL simul_level_pre: got %0d want 2", lvl4); else n_pass++;
    n_checks++; if (req4 !== 1'b1) $display("FAIL simul_req_pre: got %b want 1", req4); else n_pass++;
    man_ack4 = 1'b1;
    tick(); tick();
    v4 = 1'b1; d4 = 8'h22;
    tick();
    v4 = 1'b0;
    n_checks++; if (lvl4 !== 3'd2) $display("FAIL simul_level_post: got %0d want 2", lvl4); else n_pass++;
    n_checks++; if (req4 !== 1'b0) $display("FAIL simul_req_post: got %b want 0", req4); else n_pass++;
    auto4 = 1'b1; man_ack4 = 1'b0;
    wait_idle4(200, ok);
    n_checks++; if (!ok) $display("FAIL simul_drain_timeout: got 0 want 1"); else n_pass++;
    n_checks++; if (q4.size() != 3) $display("FAIL simul_count: got %0d want 3", q4.size()); else n_pass++;
    for (int i = 0; i < 3 && i < q4.size(); i++) begin
      n_checks++; if (q4[i] !== exp3[i]) $display("FAIL simul_order_%0d: got %h want %h", i, q4[i], exp3[i]); else n_pass++;
    end
    q4.delete();
    for (int i = 0; i < 8; i++) begin
      d4 = 8'(8'h30 + i); v4 = 1'b1;
      wait_rdy4(60, ok);
      n_checks++; if (!ok) $display("FAIL wrap_ready_timeout_%0d: got 0 want 1", i); else n_pass++;
      tick();
    end
    v4 = 1'b0;
    wait_idle4(300, ok);
    n_checks++; if (!ok) $display("FAIL wrap_drain_timeout: got 0 want 1"); else n_pass++;
    n_checks++; if (q4.size() != 8) $display("FAIL wrap_count: got %0d want 8", q4.size()); else n_pass++;
    for (int i = 0; i < 8 && i < q4.size(); i++) begin
      n_checks++; if (q4[i] !== 8'(8'h30 + i)) $display("FAIL wrap_order_%0d: got %h want %h", i, q4[i], 8'(8'h30 + i)); else n_pass++;
    end
  endtask

  task automatic test_spurious();
    auto4 = 1'b0; man_ack4 = 1'b0;
    q4.delete();
    man_ack4 = 1'b1;
    tick(); tick();
    man_ack4 = 1'b0;
    repeat (6) tick();
    n_checks++; if (req4 !== 1'b0) $display("FAIL spurious_req: got %b want 0", req4); else n_pass++;
    n_checks++; if (lvl4 !== 3'd0) $display("FAIL spurious_level: got %0d want 0", lvl4); else n_pass++;
    n_checks++; if (idle4 !== 1'b1) $display("FAIL spurious_idle: got %b want 1", idle4); else n_pass++;
    n_checks++; if (q4.size() != 0) $display("FAIL spurious_requests: got %0d want 0", q4.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    auto4 = 1'b0; man_ack4 = 1'b0;
    v4 = 1'b1; d4 = 8'h40; tick();
    d4 = 8'h41; tick();
    d4 = 8'h42; tick();
    v4 = 1'b0;
    n_checks++; if (req4 !== 1'b1) $display("FAIL rstmid_req_pre: got %b want 1", req4); else n_pass++;
    n_checks++; if (lvl4 !== 3'd3) $display("FAIL rstmid_level_pre: got %0d want 3", lvl4); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (req4 !== 1'b0) $display("FAIL rstmid_req: got %b want 0", req4); else n_pass++;
    n_checks++; if (lvl4 !== 3'd0) $display("FAIL rstmid_level: got %0d want 0", lvl4); else n_pass++;
    n_checks++; if (rdy4 !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", rdy4); else n_pass++;
    n_checks++; if (idle4 !== 1'b1) $display("FAIL rstmid_idle: got %b want 1", idle4); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (rdy4 !== 1'b1) $display("FAIL rstmid_ready_rise: got %b want 1", rdy4); else n_pass++;
    n_checks++; if (req4 !== 1'b0) $display("FAIL rstmid_req_after: got %b want 0", req4); else n_pass++;
  endtask

  task automatic test_two_phase();
    bit ok;
    q2.delete(); t2.delete();
    for (int i = 0; i < 8; i++) begin
      d2 = 8'(8'h10 + i); v2 = 1'b1;
      wait_rdy2(60, ok);
      n_checks++; if (!ok) $display("FAIL tp_ready_timeout_%0d: got 0 want 1", i); else n_pass++;
      tick();
    end
    v2 = 1'b0;
    wait_idle2(300, ok);
    n_checks++; if (!ok) $display("FAIL tp_drain_timeout: got 0 want 1"); else n_pass++;
    n_checks++; if (q2.size() != 8) $display("FAIL tp_toggles: got %0d want 8", q2.size()); else n_pass++;
    n_checks++; if (req2 !== 1'b0) $display("FAIL tp_req_final: got %b want 0", req2); else n_pass++;
    n_checks++; if (lvl2 !== 3'd0) $display("FAIL tp_level_final: got %0d want 0", lvl2); else n_pass++;
    for (int i = 0; i < 8 && i < q2.size(); i++) begin
      n_checks++; if (q2[i] !== 8'(8'h10 + i)) $display("FAIL tp_order_%0d: got %h want %h", i, q2[i], 8'(8'h10 + i)); else n_pass++;
    end
    for (int i = 0; i + 1 < t2.size(); i++) begin
      n_checks++; if (t2[i+1] - t2[i] != 6) $display("FAIL tp_interval_%0d: got %0d want 6", i, t2[i+1] - t2[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simul_wrap();
    test_spurious();
    test_reset_mid();
    test_two_phase();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
